// File: rtl/cpu_sdram_bridge_pkg.sv
// Shared definitions for the CPU-to-SDRAM-controller bridge.
//   - default CPU word / SDRAM halfword address widths
//   - FSM state encodings (plain 3-bit constants for legacy tools)
//   - halfword select constants and a byte-enable helper
package cpu_sdram_bridge_pkg;

  localparam int CPU_AW_DEF = 21;
  localparam int SD_AW_DEF  = CPU_AW_DEF + 1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WR_LO   = 3'd1;
  localparam state_t S_WR_HI   = 3'd2;
  localparam state_t S_RD_LO   = 3'd3;
  localparam state_t S_RD_HI   = 3'd4;
  localparam state_t S_RD_WAIT = 3'd5;
  localparam state_t S_DONE    = 3'd6;

  // Halfword select: appended as the LSB of the SDRAM halfword address.
  localparam logic HW_LO = 1'b0;
  localparam logic HW_HI = 1'b1;

  // Active-low byte enables for one half of a 32-bit word.
  function automatic logic [1:0] half_be_n(input logic [3:0] be, input logic hi);
    return hi ? ~be[3:2] : ~be[1:0];
  endfunction

endpackage

// File: rtl/cpu_sdram_bridge_if.sv
// Bus bundle for the CPU-to-SDRAM bridge.
//   CPU side : cpu_req/cpu_we/cpu_addr/cpu_be/cpu_wdata -> bridge,
//              cpu_rdata/cpu_ack <- bridge
//   SDRAM side: az_addr/az_rd_n/az_wr_n/az_be_n/az_data -> controller,
//              za_data/za_valid/za_waitrequest <- controller
// Modports: slave = the bridge's view, master = the environment's view
// (CPU plus SDRAM controller).
interface cpu_sdram_bridge_if
  import cpu_sdram_bridge_pkg::*;
#(
  parameter int CPU_AW = CPU_AW_DEF,
  parameter int SD_AW  = SD_AW_DEF
);
  logic              cpu_req;
  logic              cpu_we;
  logic [CPU_AW-1:0] cpu_addr;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ack;
  logic [SD_AW-1:0]  az_addr;
  logic              az_rd_n;
  logic              az_wr_n;
  logic [1:0]        az_be_n;
  logic [15:0]       az_data;
  logic [15:0]       za_data;
  logic              za_valid;
  logic              za_waitrequest;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
    output cpu_rdata, cpu_ack,
    output az_addr, az_rd_n, az_wr_n, az_be_n, az_data,
    input  za_data, za_valid, za_waitrequest
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    input  az_addr, az_rd_n, az_wr_n, az_be_n, az_data,
    output za_data, za_valid, za_waitrequest
  );
endinterface

// File: rtl/cpu_sdram_bridge.sv
// CPU (32-bit word) to SDRAM controller (16-bit halfword) bridge.
// Each CPU word N maps to halfwords 2N (bits 15:0) and 2N+1 (bits 31:16).
// Writes issue only the halves whose byte enables are non-zero; reads
// always fetch both halves and wait for two za_valid beats.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   cpu_req/we/addr/be/wdata  request, held until cpu_ack
//   cpu_rdata, cpu_ack        read data and one-cycle completion pulse
//   az_addr/rd_n/wr_n/be_n/data  command to the SDRAM controller
//   za_data/valid/waitrequest    read beats and command stall
//
// Optional feature: define BRIDGE_READ_BUFFER_EN to add a one-entry read
// buffer (address/data/valid) that answers repeated reads without SDRAM
// traffic. Any accepted write to the buffered address invalidates it.
module cpu_sdram_bridge
  import cpu_sdram_bridge_pkg::*;
#(
  parameter int CPU_AW = CPU_AW_DEF,
  parameter int SD_AW  = SD_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [CPU_AW-1:0] cpu_addr,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic [SD_AW-1:0]  az_addr,
  output logic              az_rd_n,
  output logic              az_wr_n,
  output logic [1:0]        az_be_n,
  output logic [15:0]       az_data,
  input  logic [15:0]       za_data,
  input  logic              za_valid,
  input  logic              za_waitrequest
);

  state_t            state_q, state_d;
  logic [CPU_AW-1:0] addr_q,  addr_d;
  logic [3:0]        be_q,    be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        beat_q,  beat_d;

  logic in_read;
  logic hw_sel;

`ifdef BRIDGE_READ_BUFFER_EN
  logic              buf_vld_q,  buf_vld_d;
  logic [CPU_AW-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]       buf_data_q, buf_data_d;
`endif

  assign in_read = (state_q == S_RD_LO) || (state_q == S_RD_HI) ||
                   (state_q == S_RD_WAIT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    beat_d  = beat_q;
`ifdef BRIDGE_READ_BUFFER_EN
    buf_vld_d  = buf_vld_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
`endif

    // Beats may arrive in any read state (including while RD_HI is still
    // being issued); the first is always the low half.
    if (in_read && za_valid && (beat_q != 2'd2)) begin
      if (beat_q == 2'd0) rdata_d[15:0]  = za_data;
      else                rdata_d[31:16] = za_data;
      beat_d = beat_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          be_d    = cpu_be;
          wdata_d = cpu_wdata;
          beat_d  = 2'd0;
          if (cpu_we) begin
            if (|cpu_be[1:0])      state_d = S_WR_LO;
            else if (|cpu_be[3:2]) state_d = S_WR_HI;
            else                   state_d = S_DONE;
`ifdef BRIDGE_READ_BUFFER_EN
            if (cpu_addr == buf_addr_q) buf_vld_d = 1'b0;
`endif
          end else begin
            state_d = S_RD_LO;
`ifdef BRIDGE_READ_BUFFER_EN
            if (buf_vld_q && (cpu_addr == buf_addr_q)) begin
              state_d = S_DONE;
              rdata_d = buf_data_q;
            end
`endif
          end
        end
      end
      S_WR_LO:   if (!za_waitrequest) state_d = (|be_q[3:2]) ? S_WR_HI : S_DONE;
      S_WR_HI:   if (!za_waitrequest) state_d = S_DONE;
      S_RD_LO:   if (!za_waitrequest) state_d = S_RD_HI;
      S_RD_HI:   if (!za_waitrequest) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        // beat_d already includes a beat landing this cycle, so DONE
        // follows the cycle of the second za_valid.
        if (beat_d == 2'd2) begin
          state_d = S_DONE;
`ifdef BRIDGE_READ_BUFFER_EN
          buf_vld_d  = 1'b1;
          buf_addr_d = addr_q;
          buf_data_d = rdata_d;
`endif
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      beat_q  <= beat_d;
    end
  end

`ifdef BRIDGE_READ_BUFFER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end
`endif

  // Command outputs decode straight from the registered state, so they
  // stay stable for as long as the state is held by za_waitrequest.
  assign hw_sel  = ((state_q == S_WR_HI) || (state_q == S_RD_HI)) ? HW_HI : HW_LO;
  assign az_wr_n = !((state_q == S_WR_LO) || (state_q == S_WR_HI));
  assign az_rd_n = !((state_q == S_RD_LO) || (state_q == S_RD_HI));

  always_comb begin
    az_addr = '0;
    az_data = '0;
    az_be_n = 2'b11;
    if (!az_wr_n) begin
      az_addr = SD_AW'({addr_q, hw_sel});
      az_data = hw_sel ? wdata_q[31:16] : wdata_q[15:0];
      az_be_n = half_be_n(be_q, hw_sel);
    end else if (!az_rd_n) begin
      az_addr = SD_AW'({addr_q, hw_sel});
      az_be_n = 2'b00;
    end
  end

  assign cpu_ack   = (state_q == S_DONE);
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_cpu_sdram_bridge.sv
// Scoreboard bench for cpu_sdram_bridge: directed requests push expected
// SDRAM commands and expected acks into queues; a negedge process acts as
// the SDRAM controller (wait states, delayed read beats) and checks every
// accepted command and every cpu_ack against those queues.
module tb_cpu_sdram_bridge;
  import cpu_sdram_bridge_pkg::*;

  localparam int CPU_AW = 21;
  localparam int SD_AW  = 22;

  typedef struct { logic wr; logic [SD_AW-1:0] addr; logic [15:0] data; logic [1:0] be_n; } cmd_t;
  typedef struct { logic [31:0] rdata; logic chk_rd; int lat; int acc_cyc; } ack_t;
  typedef struct { int due; logic [15:0] data; } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_sdram_bridge_if #(.CPU_AW(CPU_AW), .SD_AW(SD_AW)) bif();

  cpu_sdram_bridge #(.CPU_AW(CPU_AW), .SD_AW(SD_AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(bif.cpu_req), .cpu_we(bif.cpu_we), .cpu_addr(bif.cpu_addr),
    .cpu_be(bif.cpu_be), .cpu_wdata(bif.cpu_wdata),
    .cpu_rdata(bif.cpu_rdata), .cpu_ack(bif.cpu_ack),
    .az_addr(bif.az_addr), .az_rd_n(bif.az_rd_n), .az_wr_n(bif.az_wr_n),
    .az_be_n(bif.az_be_n), .az_data(bif.az_data),
    .za_data(bif.za_data), .za_valid(bif.za_valid),
    .za_waitrequest(bif.za_waitrequest)
  );

  cmd_t  cmd_q[$];
  ack_t  ack_q[$];
  beat_t beat_q[$];
  logic [15:0] mem [int];

  int tests = 0, fails = 0, cyc = 0, acks_seen = 0;
  int wait_cycles = 0, rd_lat = 2, stray_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- SDRAM model + monitor ----------------
  initial begin
    int   wcnt;
    cmd_t c;
    beat_t b;
    ack_t a;
    logic [15:0] v;
    int   ad;
    wcnt = 0;
    bif.za_data = '0; bif.za_valid = 1'b0; bif.za_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      bif.za_valid = 1'b0;
      bif.za_data  = '0;
      if (reset) begin
        beat_q.delete();
        wcnt = 0;
        bif.za_waitrequest = 1'b0;
      end else begin
        if (stray_cnt > 0) begin
          bif.za_valid = 1'b1; bif.za_data = 16'hBAD0; stray_cnt--;
        end else if (beat_q.size() > 0 && beat_q[0].due <= cyc) begin
          b = beat_q.pop_front();
          bif.za_valid = 1'b1; bif.za_data = b.data;
        end
        if (!bif.az_rd_n || !bif.az_wr_n) begin
          chk("strobe_exclusive", {31'd0, bif.az_rd_n | bif.az_wr_n}, 32'd1);
          if (wcnt < wait_cycles) begin
            bif.za_waitrequest = 1'b1; wcnt++;
          end else begin
            bif.za_waitrequest = 1'b0; wcnt = 0;
            if (cmd_q.size() == 0) begin
              chk("unexpected_cmd", {10'd0, bif.az_addr}, 32'hFFFF_FFFF);
            end else begin
              c = cmd_q.pop_front();
              chk("cmd_is_write", {31'd0, !bif.az_wr_n}, {31'd0, c.wr});
              chk("cmd_addr", {10'd0, bif.az_addr}, {10'd0, c.addr});
              chk("cmd_be_n", {30'd0, bif.az_be_n}, {30'd0, c.be_n});
              if (c.wr) chk("cmd_data", {16'd0, bif.az_data}, {16'd0, c.data});
            end
            ad = int'(bif.az_addr);
            v  = mem.exists(ad) ? mem[ad] : 16'h0000;
            if (!bif.az_wr_n) begin
              if (!bif.az_be_n[0]) v[7:0]  = bif.az_data[7:0];
              if (!bif.az_be_n[1]) v[15:8] = bif.az_data[15:8];
              mem[ad] = v;
            end else begin
              b.due = cyc + rd_lat; b.data = v;
              beat_q.push_back(b);
            end
          end
        end else begin
          bif.za_waitrequest = 1'b0; wcnt = 0;
        end
      end
      if (bif.cpu_ack) begin
        acks_seen++;
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", {31'd0, bif.cpu_ack}, 32'd0);
        end else begin
          a = ack_q.pop_front();
          if (a.chk_rd) chk("cpu_rdata", bif.cpu_rdata, a.rdata);
          if (a.lat > 0) chk("ack_latency", cyc - a.acc_cyc + 1, a.lat);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_cmd(input logic wr, input logic [SD_AW-1:0] addr,
                          input logic [15:0] data, input logic [1:0] be_n);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.data = data; c.be_n = be_n;
    cmd_q.push_back(c);
  endtask

  task automatic wait_ack();
    int n, t;
    n = acks_seen; t = 0;
    while (acks_seen == n && t < 200) begin
      @(negedge clk); #1; t++;
    end
    chk("ack_timeout", {31'd0, acks_seen == n}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Called #1 after a posedge with the bridge idle; the next posedge accepts.
  // Inputs are scrambled right after acceptance to show they are latched.
  task automatic issue(input logic we, input logic [CPU_AW-1:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic chk_rd, input logic [31:0] exp_rd,
                       input int exp_lat, input logic exp_ack);
    ack_t a;
    bif.cpu_req = 1'b1; bif.cpu_we = we; bif.cpu_addr = addr;
    bif.cpu_be = be; bif.cpu_wdata = wd;
    @(posedge clk); #1;
    bif.cpu_req = 1'b0; bif.cpu_we = ~we; bif.cpu_addr = CPU_AW'($urandom());
    bif.cpu_be = ~be; bif.cpu_wdata = ~wd;
    if (exp_ack) begin
      a.rdata = exp_rd; a.chk_rd = chk_rd; a.lat = exp_lat; a.acc_cyc = cyc;
      ack_q.push_back(a);
      wait_ack();
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ack"},   {31'd0, bif.cpu_ack}, 32'd0);
    chk({tag, "_rdata"}, bif.cpu_rdata, 32'd0);
    chk({tag, "_rd_n"},  {31'd0, bif.az_rd_n}, 32'd1);
    chk({tag, "_wr_n"},  {31'd0, bif.az_wr_n}, 32'd1);
    chk({tag, "_be_n"},  {30'd0, bif.az_be_n}, 32'd3);
    chk({tag, "_addr"},  {10'd0, bif.az_addr}, 32'd0);
    chk({tag, "_data"},  {16'd0, bif.az_data}, 32'd0);
  endtask

  initial begin
    int n;
    bif.cpu_req = 1'b0; bif.cpu_we = 1'b0; bif.cpu_addr = '0;
    bif.cpu_be = '0; bif.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    reset = 1'b0;

    // Full write: 0x20 <- BEEF, 0x21 <- DEAD, ack 3 cycles after acceptance.
    wait_cycles = 0;
    push_cmd(1, 22'h20, 16'hBEEF, 2'b00);
    push_cmd(1, 22'h21, 16'hDEAD, 2'b00);
    issue(1, 21'h10, 4'hF, 32'hDEADBEEF, 0, 0, 3, 1);
    // High half only.
    push_cmd(1, 22'h23, 16'h1234, 2'b00);
    issue(1, 21'h11, 4'b1100, 32'h12345678, 0, 0, 2, 1);
    // No enables: no command, ack next cycle.
    issue(1, 21'h12, 4'h0, 32'hCAFEF00D, 0, 0, 1, 1);
    // Low half only.
    push_cmd(1, 22'h26, 16'hCCDD, 2'b00);
    issue(1, 21'h13, 4'b0011, 32'hAABBCCDD, 0, 0, 2, 1);
    // Partial bytes in both halves, with wait states.
    wait_cycles = 1;
    push_cmd(1, 22'h28, 16'h3344, 2'b10);
    push_cmd(1, 22'h29, 16'h1122, 2'b10);
    issue(1, 21'h14, 4'b0101, 32'h11223344, 0, 0, 0, 1);

    // Read with two wait cycles per command.
    wait_cycles = 2; rd_lat = 2;
    push_cmd(0, 22'h20, 16'h0, 2'b00);
    push_cmd(0, 22'h21, 16'h0, 2'b00);
    issue(0, 21'h10, 4'hF, 0, 1, 32'hDEADBEEF, 0, 1);

    // Same address again.
`ifdef BRIDGE_READ_BUFFER_EN
    issue(0, 21'h10, 4'hF, 0, 1, 32'hDEADBEEF, 1, 1);
    issue(1, 21'h10, 4'h0, 32'h0, 0, 0, 1, 1);
`endif
    push_cmd(0, 22'h20, 16'h0, 2'b00);
    push_cmd(0, 22'h21, 16'h0, 2'b00);
    issue(0, 21'h10, 4'hF, 0, 1, 32'hDEADBEEF, 0, 1);

    // First beat lands in the same cycle as the RD_HI acceptance.
    wait_cycles = 0; rd_lat = 1;
    push_cmd(0, 22'h28, 16'h0, 2'b00);
    push_cmd(0, 22'h29, 16'h0, 2'b00);
    issue(0, 21'h14, 4'hF, 0, 1, 32'h00220044, 0, 1);

    wait_cycles = 1; rd_lat = 3;
    push_cmd(0, 22'h22, 16'h0, 2'b00);
    push_cmd(0, 22'h23, 16'h0, 2'b00);
    issue(0, 21'h11, 4'hF, 0, 1, 32'h12340000, 0, 1);

    // Reset in RD_WAIT after one beat: no ack, outputs back to idle values.
    wait_cycles = 0; rd_lat = 4;
    push_cmd(0, 22'h20, 16'h0, 2'b00);
    push_cmd(0, 22'h21, 16'h0, 2'b00);
    issue(0, 21'h10, 4'hF, 0, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check_idle("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    n = acks_seen;
    stray_cnt = 3;
    repeat (8) @(negedge clk);
    #1;
    chk("stray_no_ack", acks_seen, n);
    check_idle("stray");

    // Bridge still works, and any buffered entry was dropped by reset.
    @(posedge clk); #1;
    rd_lat = 2;
    push_cmd(0, 22'h20, 16'h0, 2'b00);
    push_cmd(0, 22'h21, 16'h0, 2'b00);
    issue(0, 21'h10, 4'hF, 0, 1, 32'hDEADBEEF, 0, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("cmd_queue_drained", cmd_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
